// File: rtl/out_port_fifo.sv
// CPU output-port FIFO with first-word fall-through head and full/empty/count status.
// Define OUT_PORT_OVF_EN to add the sticky overflow flag (ovf) and its clear (ovf_clr).
module out_port_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [DW-1:0]            wdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     out_valid,
    output logic [DW-1:0]            out_data,
    input  logic                     out_ready
`ifdef OUT_PORT_OVF_EN
    ,
    output logic                     ovf,
    input  logic                     ovf_clr
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          push;
    logic          pop;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign out_valid = !empty;
    // Head reads as zero while empty so the output is never X after reset.
    assign out_data  = empty ? '0 : mem[rptr];

    assign pop  = out_valid && out_ready;
    assign push = we && (!full || pop);

    // Storage is data only; the pointers and count decide what is visible.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

`ifdef OUT_PORT_OVF_EN
    logic drop;
    assign drop = we && full && !pop;

    // A clear in the same cycle as a drop takes priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_out_port_fifo.sv
// Self-checking bench for out_port_fifo against a queue-based reference model.
// Honours OUT_PORT_OVF_EN when defined, in step with the design.
module tb_out_port_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          we = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          full;
    logic          empty;
    logic [2:0]    count;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic          ovf_clr = 1'b0;
`ifdef OUT_PORT_OVF_EN
    logic          ovf;
`endif

    int tests = 0;
    int fails = 0;
    int half  = 5;

    logic [DW-1:0] q [$];
    logic          m_ovf = 1'b0;

    out_port_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .wdata     (wdata),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef OUT_PORT_OVF_EN
        ,
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
`endif
    );

    initial forever #(half) clk = ~clk;

    // Drive one cycle of inputs and advance the reference model at the edge.
    task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r);
        logic p, pu, dr;
        @(negedge clk);
        we = w; wdata = d; out_ready = r;
        @(posedge clk);
        if (reset) begin
            p  = (q.size() > 0) && r;
            pu = w && (q.size() < DEPTH || p);
            dr = w && (q.size() == DEPTH) && !p;
            if (p) void'(q.pop_front());
            if (pu) q.push_back(d);
            if (ovf_clr) m_ovf = 1'b0;
            else if (dr) m_ovf = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        #1;
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b want 1", empty); end
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %b want 0", full); end
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", out_valid); end
        tests++; if (out_data !== '0) begin fails++; $display("FAIL reset_data got %0h want 0", out_data); end
`ifdef OUT_PORT_OVF_EN
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
        #11 reset = 1'b1;
    endtask

    task automatic test_single();
        cycle(1'b1, 16'd5, 1'b0);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %b want 1", out_valid); end
        tests++; if (out_data !== 16'd5) begin fails++; $display("FAIL single_data got %0d want 5", out_data); end
        tests++; if (count !== 3'd1) begin fails++; $display("FAIL single_count got %0d want 1", count); end
        cycle(1'b0, '0, 1'b1);
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL single_drain got %b want 1", empty); end
    endtask

    task automatic test_full_drop();
        for (int i = 1; i <= 4; i++) cycle(1'b1, DW'(i), 1'b0);
        tests++; if (full !== 1'b1 || count !== 3'd4) begin fails++; $display("FAIL fill full=%b count=%0d want 1/4", full, count); end
        cycle(1'b1, 16'd9, 1'b0);
        tests++; if (count !== 3'd4 || out_data !== 16'd1) begin fails++; $display("FAIL drop count=%0d head=%0d want 4/1", count, out_data); end
`ifdef OUT_PORT_OVF_EN
        tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL drop_ovf got %b want 1", ovf); end
        ovf_clr = 1'b1;
        cycle(1'b1, 16'd9, 1'b0);
        ovf_clr = 1'b0;
        tests++; if (ovf !== m_ovf) begin fails++; $display("FAIL ovf_clr_wins got %b want %b", ovf, m_ovf); end
`endif
        for (int i = 1; i <= 4; i++) begin
            tests++; if (out_data !== DW'(i)) begin fails++; $display("FAIL pop_order got %0d want %0d", out_data, i); end
            cycle(1'b0, '0, 1'b1);
        end
        tests++; if (empty !== 1'b1 || count !== 3'd0) begin fails++; $display("FAIL drained empty=%b count=%0d want 1/0", empty, count); end
    endtask

    task automatic test_full_simul();
        for (int i = 1; i <= 4; i++) cycle(1'b1, DW'(i), 1'b0);
        cycle(1'b1, 16'd7, 1'b1);
        tests++; if (count !== 3'd4) begin fails++; $display("FAIL simul_count got %0d want 4", count); end
        for (int k = 0; k < 4; k++) begin
            tests++; if (out_data !== q[0]) begin fails++; $display("FAIL simul_order got %0d want %0d", out_data, q[0]); end
            cycle(1'b0, '0, 1'b1);
        end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL simul_empty got %b want 1", empty); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, DW'(i), 1'b0);
            tests++; if (out_data !== DW'(i)) begin fails++; $display("FAIL wrap_data got %0d want %0d", out_data, i); end
            cycle(1'b0, '0, 1'b1);
        end
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL wrap_count got %0d want 0", count); end
    endtask

    task automatic test_random();
        logic [DW-1:0] d;
        for (int i = 0; i < 300; i++) begin
            d = DW'($urandom);
            cycle(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 1)));
            tests++;
            if (count !== 3'(q.size()) || out_valid !== (q.size() > 0) ||
                full !== (q.size() == DEPTH) || empty !== (q.size() == 0) ||
                (q.size() > 0 && out_data !== q[0])) begin
                fails++;
                $display("FAIL random cyc=%0d count=%0d valid=%b data=%0h want count=%0d head=%0h",
                         i, count, out_valid, out_data, q.size(), (q.size() > 0) ? q[0] : '0);
            end
`ifdef OUT_PORT_OVF_EN
            tests++; if (ovf !== m_ovf) begin fails++; $display("FAIL random_ovf got %b want %b", ovf, m_ovf); end
`endif
        end
        while (q.size() > 0) cycle(1'b0, '0, 1'b1);
        m_ovf = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 3; i++) cycle(1'b1, DW'(10 + i), 1'b0);
        tests++; if (count !== 3'd3) begin fails++; $display("FAIL mid_pre_count got %0d want 3", count); end
        #2 reset = 1'b0;
        q.delete(); m_ovf = 1'b0;
        #1;
        tests++; if (empty !== 1'b1 || count !== 3'd0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL mid_async empty=%b count=%0d valid=%b want 1/0/0", empty, count, out_valid);
        end
        cycle(1'b1, 16'h55, 1'b1);
        tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL mid_hold count=%0d valid=%b want 0/0", count, out_valid); end
        @(negedge clk); we = 1'b0; reset = 1'b1;
        cycle(1'b1, 16'h66, 1'b0);
        tests++; if (out_data !== 16'h66 || count !== 3'd1) begin fails++; $display("FAIL mid_after data=%0h count=%0d want 66/1", out_data, count); end
        cycle(1'b0, '0, 1'b1);
    endtask

    task automatic test_cpu();
        logic [DW-1:0] r [3];
        @(negedge clk); half = 30;
        for (int k = 0; k < 3; k++) r[k] = DW'($urandom);
        repeat (9) cycle(1'b0, '0, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b1, r[k], 1'b0);
        for (int k = 0; k < 3; k++) begin
            tests++; if (out_data !== r[k] || out_valid !== 1'b1) begin
                fails++; $display("FAIL cpu_out got %0h valid=%b want %0h", out_data, out_valid, r[k]);
            end
            cycle(1'b0, '0, 1'b1);
        end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL cpu_empty got %b want 1", empty); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_drop();
        test_full_simul();
        test_wrap();
        test_random();
        test_reset_mid();
        test_cpu();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
